// File: rtl/mk14_disp_kbd.sv
// MK14 display/keypad peripheral: memory-mapped segment latches, a column
// scan engine driving a common-cathode 7-seg array, and a debounced keypad
// read back through the same address window.

// Per-column state: the segment latch for this digit plus its key debouncer.
module mk14_kbd_col (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       smp,
  input  logic [3:0] row_s,
  output logic [7:0] seg,
  output logic [3:0] key
);
  logic [3:0] key_prev;

  // Segment latch, and key state that only moves once two frames agree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg      <= '0;
      key      <= 4'hF;
      key_prev <= 4'hF;
    end else begin
      if (we) seg <= wdata;
      if (smp) begin
        if (row_s == key_prev) key <= row_s;
        key_prev <= row_s;
      end
    end
  end
endmodule

module mk14_disp_kbd #(
  parameter logic [15:0] BASE_ADDR    = 16'h0D00,
  parameter logic [15:0] ADDR_MASK    = 16'hFF00,
  parameter int          DIGITS       = 8,
  parameter int          SCAN_CYCLES  = 50000,
  parameter int          BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [15:0]       mem_addr,
  input  logic              mem_write_en,
  input  logic [7:0]        mem_write_data,
  output logic [7:0]        rd_data,
  output logic              rd_hit,
  input  logic [3:0]        kbd_row_n,
  output logic [DIGITS-1:0] digit_sel,
  output logic [7:0]        seg_out
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SC_LAST  = SW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] BLANK    = SW'(BLANK_CYCLES);
  localparam logic [CW-1:0] COL_LAST = CW'(DIGITS - 1);

  logic [SW-1:0] scan_cnt;
  logic [CW-1:0] col;
  logic [3:0]    row_m, row_s;

  logic [DIGITS-1:0][7:0] seg_ram;
  logic [DIGITS-1:0][3:0] key_state;

  // Address decode; the window mirrors every 16 bytes, only DIGITS slots exist.
  logic       hit, valid, wr_ok, smp_now, blank;
  logic [3:0] idx;
  assign hit     = (mem_addr & ADDR_MASK) == BASE_ADDR;
  assign idx     = mem_addr[3:0];
  assign valid   = hit && ({1'b0, idx} < 5'(DIGITS));
  assign wr_ok   = en && mem_write_en && valid;
  assign smp_now = (scan_cnt == SC_LAST);
  assign blank   = (scan_cnt < BLANK);

  // One column slice per digit: segment latch and keypad debouncer.
  for (genvar g = 0; g < DIGITS; g++) begin : g_col
    mk14_kbd_col u_col (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok && (idx == 4'(g))),
      .wdata (mem_write_data),
      .smp   (smp_now && (col == CW'(g))),
      .row_s (row_s),
      .seg   (seg_ram[g]),
      .key   (key_state[g])
    );
  end

  // Select the addressed column's keys for reads and the scanned digit's pattern.
  logic [3:0] rd_key;
  logic [7:0] disp_seg;
  always_comb begin
    rd_key   = 4'hF;
    disp_seg = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == 4'(d)) rd_key = key_state[d];
      if (col == CW'(d)) disp_seg = seg_ram[d];
    end
  end

  // Two-flop synchronizer for the asynchronous keypad rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= kbd_row_n;
      row_s <= row_m;
    end
  end

  // Free-running column scan; advances the column on each count wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      col      <= '0;
    end else if (smp_now) begin
      scan_cnt <= '0;
      col      <= (col == COL_LAST) ? '0 : col + CW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Registered display drive, blanked at the start of each column to avoid ghosting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_sel <= '0;
      seg_out   <= '0;
    end else begin
      digit_sel <= blank ? '0 : (DIGITS'(1) << col);
      seg_out   <= blank ? '0 : disp_seg;
    end
  end

  // Registered read port; key rows land in the upper nibble, MK14-style.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_hit  <= 1'b0;
      rd_data <= 8'hFF;
    end else begin
      rd_hit  <= hit;
      rd_data <= valid ? {rd_key, 4'hF} : 8'hFF;
    end
  end
endmodule

// File: tb/tb_mk14_disp_kbd.sv
// Directed bench for mk14_disp_kbd with a short scan period; reads go
// through a scoreboard queue, display output is checked against a
// time-since-reset model of the scan.
module tb_mk14_disp_kbd;
  localparam int D     = 8;
  localparam int SC    = 20;
  localparam int BL    = 2;
  localparam int FRAME = D * SC;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [15:0]  mem_addr = 16'h0;
  logic         mem_write_en = 1'b0;
  logic [7:0]   mem_write_data = 8'h0;
  logic [7:0]   rd_data;
  logic         rd_hit;
  logic [3:0]   kbd_row_n = 4'hF;
  logic [D-1:0] digit_sel;
  logic [7:0]   seg_out;

  mk14_disp_kbd #(
    .BASE_ADDR(16'h0D00), .ADDR_MASK(16'hFF00), .DIGITS(D),
    .SCAN_CYCLES(SC), .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mem_addr(mem_addr),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .rd_data(rd_data), .rd_hit(rd_hit), .kbd_row_n(kbd_row_n),
    .digit_sel(digit_sel), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was released.
  int tick;
  always @(posedge clk) begin
    if (!rst_n) tick <= 0;
    else        tick <= tick + 1;
  end

  int         n_chk = 0, n_pass = 0, n_fail = 0;
  logic [8:0] sb_q[$];
  logic [7:0] seg_exp[D];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h (tick %0d)", tag, obs, exp, tick);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic e);
    en = e; mem_addr = a; mem_write_data = d; mem_write_en = 1'b1;
    step();
    mem_write_en = 1'b0; en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic h, input logic [7:0] d);
    logic [8:0] e;
    mem_addr = a;
    sb_q.push_back({h, d});
    step();
    e = sb_q.pop_front();
    chk(tag, {7'd0, rd_hit, rd_data}, {7'd0, e});
  endtask

  // Advance until the scan is at column c, count n (state before the next edge).
  task automatic goto(input int c, input int n);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (tick % FRAME == c * SC + n) return;
      step();
    end
    n_chk++; n_fail++;
    $error("FAIL goto_timeout: got tick %0d want col %0d cnt %0d", tick, c, n);
  endtask

  // Check digit_sel/seg_out every cycle for n cycles.
  task automatic sweep(input string tag, input int n);
    int p, cnt, c;
    logic [15:0] one, eds, eseg;
    one = 16'd1;
    for (int i = 0; i < n; i++) begin
      step();
      p = tick - 1; cnt = p % SC; c = (p / SC) % D;
      if (tick == 0 || cnt < BL) begin
        eds = '0; eseg = '0;
      end else begin
        eds = one << c; eseg = {8'd0, seg_exp[c]};
      end
      chk({tag, "_dsel"}, {8'd0, digit_sel}, eds);
      chk({tag, "_seg"},  {8'd0, seg_out},   eseg);
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) seg_exp[i] = 8'h00;

    // Reset state
    step(); step();
    chk("rst_dsel", {8'd0, digit_sel}, 16'h0);
    chk("rst_seg",  {8'd0, seg_out},   16'h0);
    chk("rst_rd",   {7'd0, rd_hit, rd_data}, {7'd0, 1'b0, 8'hFF});
    rst_n = 1'b1;

    // Idle scan: column sequence with blanking, all segments dark
    sweep("idle", FRAME + SC);
    rd("rd_0d00", 16'h0D00, 1'b1, 8'hFF);

    // Writes: direct, mirrored, disabled, and out-of-range index
    wr(16'h0D03, 8'h3F, 1'b1); seg_exp[3] = 8'h3F;
    wr(16'h0DF5, 8'h06, 1'b1); seg_exp[5] = 8'h06;
    wr(16'h0D02, 8'h7F, 1'b0);
    wr(16'h0D0A, 8'h55, 1'b1);
    step();
    sweep("disp", FRAME);
    rd("rd_0d0a", 16'h0D0A, 1'b1, 8'hFF);
    rd("rd_0e00", 16'h0E00, 1'b0, 8'hFF);
    rd("rd_0d03", 16'h0D03, 1'b1, 8'hFF);

    // Held key on row 0: reported only after the second col-5 sample
    goto(0, 0); kbd_row_n = 4'b1110;
    goto(5, SC - 1);
    rd("key_f1a", 16'h0D05, 1'b1, 8'hFF);
    rd("key_f1b", 16'h0D05, 1'b1, 8'hFF);
    goto(5, SC - 1);
    rd("key_f2a", 16'h0D05, 1'b1, 8'hFF);
    rd("key_f2b", 16'h0D05, 1'b1, 8'hEF);

    // Release: needs two frames as well
    kbd_row_n = 4'hF;
    goto(5, SC - 1);
    rd("rel_f1a", 16'h0D05, 1'b1, 8'hEF);
    rd("rel_f1b", 16'h0D05, 1'b1, 8'hEF);
    goto(5, SC - 1);
    rd("rel_f2a", 16'h0D05, 1'b1, 8'hEF);
    rd("rel_f2b", 16'h0D05, 1'b1, 8'hFF);

    // Single-frame glitch on column 2 is never reported
    goto(2, SC - 4); kbd_row_n = 4'b0111;
    goto(2, SC - 1);
    rd("gl_a", 16'h0D02, 1'b1, 8'hFF);
    kbd_row_n = 4'hF;
    rd("gl_b", 16'h0D02, 1'b1, 8'hFF);
    goto(2, SC - 1);
    rd("gl_c", 16'h0D02, 1'b1, 8'hFF);
    rd("gl_d", 16'h0D02, 1'b1, 8'hFF);

    // Two keys in one column reported bitwise
    goto(0, 0); kbd_row_n = 4'b1010;
    goto(1, SC - 1);
    rd("mk_f1a", 16'h0D01, 1'b1, 8'hFF);
    rd("mk_f1b", 16'h0D01, 1'b1, 8'hFF);
    goto(1, SC - 1);
    rd("mk_f2a", 16'h0D01, 1'b1, 8'hFF);
    rd("mk_f2b", 16'h0D01, 1'b1, 8'hAF);

    // Write to the displayed digit, then reset mid-column 4
    goto(4, 8);
    wr(16'h0D04, 8'h5B, 1'b1); seg_exp[4] = 8'h5B;
    step();
    chk("live_seg",  {8'd0, seg_out},   16'h005B);
    chk("live_dsel", {8'd0, digit_sel}, 16'h0010);
    rst_n = 1'b0;
    step();
    chk("mrst_dsel", {8'd0, digit_sel}, 16'h0);
    chk("mrst_seg",  {8'd0, seg_out},   16'h0);
    chk("mrst_rd",   {7'd0, rd_hit, rd_data}, {7'd0, 1'b0, 8'hFF});
    rst_n = 1'b1;
    kbd_row_n = 4'hF;
    for (int i = 0; i < D; i++) seg_exp[i] = 8'h00;
    sweep("post", FRAME + SC);
    rd("post_k1", 16'h0D01, 1'b1, 8'hFF);
    rd("post_k5", 16'h0D05, 1'b1, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
